// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM states and helpers
// for the SPI flash responder.
package spi_flash_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_FREAD = 8'h0B;
  localparam logic [7:0] OP_RDID  = 8'h9F;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;

  localparam int DUMMY_CYCLES = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_ID,
    ST_SR,
    ST_IGNORE
  } state_t;

  function automatic logic is_resp(input state_t s);
    return (s == ST_DATA) || (s == ST_ID) || (s == ST_SR);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// SPI pin synchronizers with sclk edge
// detection in the system clock domain.
module spi_pin_sync #(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cs_n,
  input  logic si,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_n_s,
  output logic si_s
);

  logic [SYNC-1:0] sclk_q;
  logic [SYNC-1:0] cs_q;
  logic [SYNC-1:0] si_q;
  logic            sclk_d;

  // shift raw pins through the sync chains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= '0;
      cs_q   <= '1;
      si_q   <= '0;
      sclk_d <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[SYNC-2:0], sclk};
      cs_q   <= {cs_q[SYNC-2:0], cs_n};
      si_q   <= {si_q[SYNC-2:0], si};
      sclk_d <= sclk_q[SYNC-1];
    end
  end

  assign sclk_rise = sclk_q[SYNC-1] & ~sclk_d;
  assign sclk_fall = ~sclk_q[SYNC-1] & sclk_d;
  assign cs_n_s    = cs_q[SYNC-1];
  assign si_s      = si_q[SYNC-1];

endmodule

// File: rtl/spi_flash_resp.sv
// Oversampled mode-0 SPI flash responder
// serving reads from an on-chip memory port.
module spi_flash_resp
  import spi_flash_pkg::*;
#(
  parameter int          AWIDTH   = 24,
  parameter logic [23:0] JEDEC_ID = 24'h016017,
  parameter int          SYNC     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              si,
  output logic              so,
  output logic              so_oe,
  output logic              mem_req,
  output logic [AWIDTH-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  input  logic              wip,
  output logic              cmd_err,
  output logic              underrun
);

  logic rise;
  logic fall;
  logic cs_hi;
  logic si_s;

  state_t            state;
  logic [2:0]        bitcnt;
  logic [1:0]        bytecnt;
  logic [6:0]        cmd_sh;
  logic              fast;
  logic [AWIDTH-1:0] addr;
  logic              wel;

  logic [7:0]        sh;
  logic [7:0]        pbuf;
  logic              pvalid;
  logic              pend;
  logic [1:0]        drop;
  logic [1:0]        drop_n;

  logic [7:0]        opcode;
  logic [AWIDTH-1:0] addr_nx;
  logic [AWIDTH-1:0] req_addr;
  logic              ack_live;
  logic              ack_drop;
  logic              load;
  logic              last_addr;
  logic              issue;
  logic              starve;
  logic [7:0]        resp_byte;

  spi_pin_sync #(
    .SYNC(SYNC)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .si       (si),
    .sclk_rise(rise),
    .sclk_fall(fall),
    .cs_n_s   (cs_hi),
    .si_s     (si_s)
  );

  assign opcode    = {cmd_sh, si_s};
  assign addr_nx   = {addr[AWIDTH-2:0], si_s};
  assign ack_live  = mem_ack && (drop == 2'd0) && pend;
  assign ack_drop  = mem_ack && (drop != 2'd0);
  assign load      = fall && !cs_hi && is_resp(state)
                     && (bitcnt == 3'd0);
  assign last_addr = rise && (state == ST_ADDR)
                     && (bytecnt == 2'd2) && (bitcnt == 3'd7);
  assign issue     = !cs_hi
                     && (last_addr || (load && state == ST_DATA));
  assign req_addr  = last_addr ? addr_nx : addr + AWIDTH'(1);
  assign starve    = load && (state == ST_DATA)
                     && !ack_live && !pvalid;

  // pick the next byte to present at a byte boundary
  always_comb begin
    resp_byte = 8'hFF;
    case (state)
      ST_DATA: begin
        if (ack_live)    resp_byte = mem_rdata;
        else if (pvalid) resp_byte = pbuf;
      end
      ST_ID: begin
        case (bytecnt)
          2'd0:    resp_byte = JEDEC_ID[23:16];
          2'd1:    resp_byte = JEDEC_ID[15:8];
          default: resp_byte = JEDEC_ID[7:0];
        endcase
      end
      ST_SR:   resp_byte = {6'b0, wel, wip};
      default: resp_byte = 8'hFF;
    endcase
  end

  // acks still owed to requests nobody wants any more
  always_comb begin
    drop_n = drop;
    if (ack_drop) drop_n = drop_n - 2'd1;
    if (pend && !ack_live && (cs_hi || issue)
        && drop_n != 2'd3)
      drop_n = drop_n + 2'd1;
  end

  // command, address and state sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bitcnt  <= 3'd0;
      bytecnt <= 2'd0;
      cmd_sh  <= 7'd0;
      fast    <= 1'b0;
      addr    <= '0;
      wel     <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      if (cs_hi) begin
        state  <= ST_IDLE;
        bitcnt <= 3'd0;
      end else begin
        case (state)
          ST_IDLE: begin
            state  <= ST_CMD;
            bitcnt <= 3'd0;
          end
          ST_CMD: if (rise) begin
            cmd_sh <= opcode[6:0];
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              bytecnt <= 2'd0;
              fast    <= (opcode == OP_FREAD);
              unique case (1'b1)
                opcode == OP_READ,
                opcode == OP_FREAD: state <= ST_ADDR;
                opcode == OP_RDID:  state <= ST_ID;
                opcode == OP_RDSR:  state <= ST_SR;
                opcode == OP_WREN: begin
                  wel   <= 1'b1;
                  state <= ST_IGNORE;
                end
                opcode == OP_WRDI: begin
                  wel   <= 1'b0;
                  state <= ST_IGNORE;
                end
                default: begin
                  cmd_err <= 1'b1;
                  state   <= ST_IGNORE;
                end
              endcase
            end
          end
          ST_ADDR: if (rise) begin
            addr   <= addr_nx;
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              if (bytecnt == 2'd2) begin
                bytecnt <= 2'd0;
                state   <= fast ? ST_DUMMY : ST_DATA;
              end else begin
                bytecnt <= bytecnt + 2'd1;
              end
            end
          end
          ST_DUMMY: if (rise) begin
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'(DUMMY_CYCLES - 1))
              state <= ST_DATA;
          end
          ST_DATA: if (fall) begin
            bitcnt <= bitcnt + 3'd1;
            if (load) addr <= addr + AWIDTH'(1);
          end
          ST_ID: if (fall) begin
            bitcnt <= bitcnt + 3'd1;
            if (load)
              bytecnt <= (bytecnt == 2'd2) ? 2'd0
                                           : bytecnt + 2'd1;
          end
          ST_SR: if (fall) bitcnt <= bitcnt + 3'd1;
          default: state <= state;
        endcase
      end
    end
  end

  // memory requests and the one-byte prefetch buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
      pend     <= 1'b0;
      pvalid   <= 1'b0;
      pbuf     <= 8'd0;
      drop     <= 2'd0;
    end else begin
      drop    <= drop_n;
      mem_req <= issue;
      if (issue) mem_addr <= req_addr;
      if (issue)                    pend <= 1'b1;
      else if (ack_live || cs_hi)   pend <= 1'b0;
      if (cs_hi || issue) begin
        pvalid <= 1'b0;
      end else if (ack_live) begin
        pvalid <= 1'b1;
        pbuf   <= mem_rdata;
      end
    end
  end

  // output shifter, pad enable and underrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      so       <= 1'b1;
      sh       <= 8'hFF;
      so_oe    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (starve) underrun <= 1'b1;
      if (!is_resp(state))      so_oe <= 1'b0;
      else if (fall && !cs_hi)  so_oe <= 1'b1;
      if (cs_hi || !is_resp(state)) begin
        so <= 1'b1;
        sh <= 8'hFF;
      end else if (fall) begin
        if (bitcnt == 3'd0) begin
          so <= resp_byte[7];
          sh <= {resp_byte[6:0], 1'b1};
        end else begin
          so <= sh[7];
          sh <= {sh[6:0], 1'b1};
        end
      end
    end
  end

endmodule
